// File: rtl/ram_access_ctrl.sv
// rtl/ram_access_ctrl.sv - host/stream arbiter and access sequencer for a single-port byte RAM
//
// Shares one single-port RAM between a req/ack host port (single byte reads and
// writes) and a stream engine that fetches a contiguous block and hands it out
// byte by byte over valid/ready. Every access runs IDLE -> ACC -> WAIT; the RAM
// strobe is high in ACC and the read data is captured in WAIT.
//
// Ports
//   i_clk, i_rst                       clock, synchronous active-high reset
//   i_host_req/rw/addr/wdata           host request (held until o_host_ack)
//   o_host_ack, o_host_rdata           completion pulse, read result (held)
//   i_str_start/base/len               stream start pulse, block base, byte count
//   o_str_busy, o_str_done             transfer in progress, end-of-transfer pulse
//   o_str_data/valid, i_str_ready      stream byte output handshake
//   o_ram_en/rw/addr/wdata, i_ram_rdata RAM side (read data one cycle after en)
module ram_access_ctrl #(
    parameter int AW = 19,
    parameter int DW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_host_req,
    input  logic          i_host_rw,
    input  logic [AW-1:0] i_host_addr,
    input  logic [DW-1:0] i_host_wdata,
    output logic          o_host_ack,
    output logic [DW-1:0] o_host_rdata,
    input  logic          i_str_start,
    input  logic [AW-1:0] i_str_base,
    input  logic [AW-1:0] i_str_len,
    output logic          o_str_busy,
    output logic [DW-1:0] o_str_data,
    output logic          o_str_valid,
    input  logic          i_str_ready,
    output logic          o_str_done,
    output logic          o_ram_en,
    output logic          o_ram_rw,
    output logic [AW-1:0] o_ram_addr,
    output logic [DW-1:0] o_ram_wdata,
    input  logic [DW-1:0] i_ram_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam logic OWN_HOST = 1'b0;
    localparam logic OWN_STR  = 1'b1;

    state_t        r_state;
    state_t        w_next_state;

    logic          r_last_grant;
    logic          r_owner;
    logic [AW-1:0] r_ram_addr;
    logic          r_ram_rw;
    logic [DW-1:0] r_ram_wdata;
    logic          r_host_ack;
    logic [DW-1:0] r_host_rdata;
    logic          r_str_busy;
    logic [AW-1:0] r_str_addr;
    logic [AW-1:0] r_fetch_cnt;
    logic [AW-1:0] r_cons_cnt;
    logic [DW-1:0] r_str_data;
    logic          r_str_valid;
    logic          r_str_done;

    logic          w_host_elig;
    logic          w_str_elig;
    logic          w_grant_host;
    logic          w_grant_str;
    logic          w_handshake;
    logic          w_start_ok;

    // The host is held off on its own ack cycle: it is still dropping req then.
    assign w_host_elig  = (r_state == ST_IDLE) && i_host_req && !r_host_ack;
    // A fetch is only issued into an empty buffer; a consume in this cycle
    // frees the buffer from the next cycle on, since r_str_valid is registered.
    assign w_str_elig   = (r_state == ST_IDLE) && r_str_busy &&
                          (r_fetch_cnt != '0) && !r_str_valid;
    // Round robin: on a tie the requester not granted last wins.
    assign w_grant_host = w_host_elig && (!w_str_elig || (r_last_grant == OWN_STR));
    assign w_grant_str  = w_str_elig && (!w_host_elig || (r_last_grant == OWN_HOST));
    assign w_handshake  = r_str_valid && i_str_ready;
    assign w_start_ok   = i_str_start && !r_str_busy;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_host || w_grant_str) begin
                    w_next_state = ST_ACC;
                end
            end
            ST_ACC:  w_next_state = ST_WAIT;
            ST_WAIT: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_grant <= OWN_STR;
            r_owner      <= OWN_HOST;
            r_ram_addr   <= '0;
            r_ram_rw     <= 1'b0;
            r_ram_wdata  <= '0;
            r_host_ack   <= 1'b0;
            r_host_rdata <= '0;
            r_str_busy   <= 1'b0;
            r_str_addr   <= '0;
            r_fetch_cnt  <= '0;
            r_cons_cnt   <= '0;
            r_str_data   <= '0;
            r_str_valid  <= 1'b0;
            r_str_done   <= 1'b0;
        end else begin
            r_host_ack <= 1'b0;
            r_str_done <= 1'b0;

            // Access parameters are latched at grant and held through ACC/WAIT.
            if (w_grant_host) begin
                r_owner      <= OWN_HOST;
                r_last_grant <= OWN_HOST;
                r_ram_addr   <= i_host_addr;
                r_ram_rw     <= i_host_rw;
                r_ram_wdata  <= i_host_wdata;
            end else if (w_grant_str) begin
                r_owner      <= OWN_STR;
                r_last_grant <= OWN_STR;
                r_ram_addr   <= r_str_addr;
                r_ram_rw     <= 1'b0;
                r_ram_wdata  <= '0;
                r_str_addr   <= r_str_addr + 1'b1;
                r_fetch_cnt  <= r_fetch_cnt - 1'b1;
            end

            // Writes also finish through WAIT so ack latency is direction-independent.
            if (r_state == ST_WAIT) begin
                if (r_owner == OWN_HOST) begin
                    r_host_ack <= 1'b1;
                    if (!r_ram_rw) begin
                        r_host_rdata <= i_ram_rdata;
                    end
                end else begin
                    r_str_data  <= i_ram_rdata;
                    r_str_valid <= 1'b1;
                end
            end

            // A stream capture never coincides with a handshake: fetches are
            // only granted while the buffer is empty.
            if (w_handshake) begin
                r_str_valid <= 1'b0;
                r_cons_cnt  <= r_cons_cnt - 1'b1;
                if (r_cons_cnt == AW'(1)) begin
                    r_str_busy <= 1'b0;
                    r_str_done <= 1'b1;
                end
            end

            if (w_start_ok) begin
                if (i_str_len == '0) begin
                    r_str_done <= 1'b1;
                end else begin
                    r_str_busy  <= 1'b1;
                    r_str_addr  <= i_str_base;
                    r_fetch_cnt <= i_str_len;
                    r_cons_cnt  <= i_str_len;
                end
            end
        end
    end

    assign o_host_ack   = r_host_ack;
    assign o_host_rdata = r_host_rdata;
    assign o_str_busy   = r_str_busy;
    assign o_str_data   = r_str_data;
    assign o_str_valid  = r_str_valid;
    assign o_str_done   = r_str_done;
    assign o_ram_en     = (r_state == ST_ACC);
    assign o_ram_rw     = r_ram_rw;
    assign o_ram_addr   = r_ram_addr;
    assign o_ram_wdata  = r_ram_wdata;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb/tb_ram_access_ctrl.sv - self-checking bench for ram_access_ctrl
module tb_ram_access_ctrl;

    localparam int AW       = 19;
    localparam int DW       = 8;
    localparam int MEMSZ    = 1 << AW;
    localparam int HOST_TAG = 'h50000;

    logic          clk        = 1'b0;
    logic          rst        = 1'b1;
    logic          host_req   = 1'b0;
    logic          host_rw    = 1'b0;
    logic [AW-1:0] host_addr  = '0;
    logic [DW-1:0] host_wdata = '0;
    logic          host_ack;
    logic [DW-1:0] host_rdata;
    logic          str_start  = 1'b0;
    logic [AW-1:0] str_base   = '0;
    logic [AW-1:0] str_len    = '0;
    logic          str_busy;
    logic [DW-1:0] str_data;
    logic          str_valid;
    logic          str_ready  = 1'b0;
    logic          str_done;
    logic          ram_en;
    logic          ram_rw;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata  = '0;

    bit   [7:0]    ram    [0:MEMSZ-1];
    bit            ram_wr [0:MEMSZ-1];
    logic [7:0]    ref_mem [int];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int last_rd = 0;

    ram_access_ctrl #(.AW(AW), .DW(DW)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_host_req   (host_req),
        .i_host_rw    (host_rw),
        .i_host_addr  (host_addr),
        .i_host_wdata (host_wdata),
        .o_host_ack   (host_ack),
        .o_host_rdata (host_rdata),
        .i_str_start  (str_start),
        .i_str_base   (str_base),
        .i_str_len    (str_len),
        .o_str_busy   (str_busy),
        .o_str_data   (str_data),
        .o_str_valid  (str_valid),
        .i_str_ready  (str_ready),
        .o_str_done   (str_done),
        .o_ram_en     (ram_en),
        .o_ram_rw     (ram_rw),
        .o_ram_addr   (ram_addr),
        .o_ram_wdata  (ram_wdata),
        .i_ram_rdata  (ram_rdata)
    );

    always #5 clk = ~clk;

    // Unwritten RAM locations read back a fixed address-derived pattern.
    function automatic int init_val(int a);
        return ((a * 37) + ((a >>> 8) * 11) + 7) & 'hFF;
    endfunction

    function automatic int exp_byte(int a);
        int m;
        m = a & (MEMSZ - 1);
        if (ref_mem.exists(m)) return int'(ref_mem[m]);
        return init_val(m);
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_en) begin
            if (ram_rw) begin
                ram[ram_addr]    <= ram_wdata;
                ram_wr[ram_addr] <= 1'b1;
            end else begin
                ram_rdata <= ram_wr[ram_addr] ? ram[ram_addr] : 8'(init_val(int'(ram_addr)));
            end
        end
    end

    // Event monitor, sampled mid-cycle.
    logic [AW-1:0] q_en[$];
    int q_sd[$];
    int q_hs[$];
    int q_dn[$];
    int n_regrant = 0;
    logic prev_ack = 1'b0;
    int m_en, m_sd, m_dn, m_rg;

    always @(negedge clk) begin
        if (ram_en) q_en.push_back(ram_addr);
        if (str_valid && str_ready) begin
            q_sd.push_back(int'(str_data));
            q_hs.push_back(cyc);
        end
        if (str_done) q_dn.push_back(cyc);
        if (prev_ack && ram_en && (ram_addr == AW'(HOST_TAG))) n_regrant++;
        prev_ack = host_ack;
    end

    task automatic mark();
        m_en = q_en.size();
        m_sd = q_sd.size();
        m_dn = q_dn.size();
        m_rg = n_regrant;
    endtask

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got timeout, expected completion", name);
    endtask

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_zero(string tag);
        check({tag, " host_ack"},   int'(host_ack),   0);
        check({tag, " host_rdata"}, int'(host_rdata), 0);
        check({tag, " str_busy"},   int'(str_busy),   0);
        check({tag, " str_data"},   int'(str_data),   0);
        check({tag, " str_valid"},  int'(str_valid),  0);
        check({tag, " str_done"},   int'(str_done),   0);
        check({tag, " ram_en"},     int'(ram_en),     0);
        check({tag, " ram_rw"},     int'(ram_rw),     0);
        check({tag, " ram_addr"},   int'(ram_addr),   0);
        check({tag, " ram_wdata"},  int'(ram_wdata),  0);
    endtask

    // Host access from IDLE with no competing stream: strict cycle timing.
    task automatic host_fixed(string name, logic rw, int addr, int wdata, int exp_rd);
        host_req   = 1'b1;
        host_rw    = rw;
        host_addr  = AW'(addr);
        host_wdata = DW'(wdata);
        step();
        check({name, " c1 ram_en"},   int'(ram_en),   1);
        check({name, " c1 ram_addr"}, int'(ram_addr), addr);
        check({name, " c1 ram_rw"},   int'(ram_rw),   int'(rw));
        if (rw) check({name, " c1 ram_wdata"}, int'(ram_wdata), wdata);
        check({name, " c1 ack"},      int'(host_ack), 0);
        step();
        check({name, " c2 ram_en"},   int'(ram_en),   0);
        check({name, " c2 ack"},      int'(host_ack), 0);
        step();
        check({name, " c3 ack"},      int'(host_ack), 1);
        check({name, " c3 rdata"},    int'(host_rdata), exp_rd);
        host_req = 1'b0;
        if (rw) ref_mem[addr & (MEMSZ - 1)] = 8'(wdata);
        else last_rd = exp_rd;
        step();
        check({name, " c4 ack"},      int'(host_ack), 0);
    endtask

    task automatic wait_done(string name, int bound, int ready_pct);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            str_ready = ($urandom_range(99) < 32'(ready_pct));
            step();
            if (str_done) begin
                ok = 1'b1;
                break;
            end
        end
        str_ready = 1'b0;
        if (!ok) timeout_fail({name, " done"});
    endtask

    task automatic start_stream(int base, int len);
        str_base  = AW'(base);
        str_len   = AW'(len);
        str_start = 1'b1;
        step();
        str_start = 1'b0;
    endtask

    task automatic check_stream(string name, int base, int len, bit chk_en);
        check({name, " byte count"}, q_sd.size() - m_sd, len);
        for (int i = 0; i < len; i++) begin
            if (m_sd + i < q_sd.size())
                check($sformatf("%s byte%0d", name, i), q_sd[m_sd + i], exp_byte(base + i));
        end
        check({name, " done count"}, q_dn.size() - m_dn, 1);
        if ((q_dn.size() > m_dn) && (q_hs.size() > m_sd))
            check({name, " done latency"}, q_dn[m_dn], q_hs[q_hs.size() - 1] + 1);
        check({name, " busy after"}, int'(str_busy), 0);
        if (chk_en) begin
            check({name, " fetch count"}, q_en.size() - m_en, len);
            for (int i = 0; i < len; i++) begin
                if (m_en + i < q_en.size())
                    check($sformatf("%s addr%0d", name, i), int'(q_en[m_en + i]),
                          (base + i) & (MEMSZ - 1));
            end
        end
    endtask

    task automatic host_rand(int nops);
        int addr;
        int wd;
        bit ok;
        logic rw;
        for (int op = 0; op < nops; op++) begin
            step($urandom_range(0, 6));
            rw   = 1'($urandom_range(0, 1));
            addr = 'h48000 + $urandom_range(0, 255);
            wd   = $urandom_range(0, 255);
            host_req   = 1'b1;
            host_rw    = rw;
            host_addr  = AW'(addr);
            host_wdata = DW'(wd);
            ok = 1'b0;
            for (int k = 0; k < 40; k++) begin
                step();
                if (host_ack) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) timeout_fail("rand host ack");
            else if (rw) ref_mem[addr] = 8'(wd);
            else check($sformatf("rand host rd 0x%0h", addr), int'(host_rdata), exp_byte(addr));
            host_req = 1'b0;
            step();
        end
    endtask

    typedef struct {
        logic rw;
        int   addr;
        int   wdata;
        int   exp_rd;
    } host_vec_t;

    host_vec_t hv [7];

    initial begin
        int c0;
        bit ok;

        hv[0] = '{1'b1, 'h00010, 'hA5, 'h00};
        hv[1] = '{1'b0, 'h00010, 'h00, 'hA5};
        hv[2] = '{1'b1, 'h7FFFF, 'h3C, 'hA5};
        hv[3] = '{1'b0, 'h7FFFF, 'h00, 'h3C};
        hv[4] = '{1'b1, 'h00011, 'hC3, 'h3C};
        hv[5] = '{1'b0, 'h00010, 'h00, 'hA5};
        hv[6] = '{1'b0, 'h00011, 'h00, 'hC3};

        step(3);
        check_zero("reset");
        rst = 1'b0;
        step();

        for (int i = 0; i < 7; i++)
            host_fixed($sformatf("hv%0d", i), hv[i].rw, hv[i].addr, hv[i].wdata, hv[i].exp_rd);

        host_fixed("pre0", 1'b1, 0, 'h11, last_rd);
        host_fixed("pre1", 1'b1, 1, 'h22, last_rd);
        host_fixed("pre2", 1'b1, 2, 'h33, last_rd);
        host_fixed("pre3", 1'b1, 3, 'h44, last_rd);

        // Four-byte stream, consumer always ready: one byte every 4 cycles.
        mark();
        c0 = cyc;
        str_ready = 1'b1;
        start_stream(0, 4);
        check("s4 busy after start", int'(str_busy), 1);
        wait_done("s4", 100, 100);
        step(2);
        check_stream("s4", 0, 4, 1'b1);
        if (q_hs.size() > m_sd) check("s4 first byte cycle", q_hs[m_sd], c0 + 4);
        for (int i = 1; i < 4; i++)
            if (m_sd + i < q_hs.size())
                check($sformatf("s4 spacing%0d", i), q_hs[m_sd + i] - q_hs[m_sd + i - 1], 4);

        // Address counter wraps at the top of the address space.
        mark();
        start_stream('h7FFFE, 3);
        wait_done("wrap", 100, 100);
        step(2);
        check_stream("wrap", 'h7FFFE, 3, 1'b1);

        // Zero-length start: immediate done, never busy, no RAM access.
        mark();
        start_stream('h123, 0);
        check("len0 done", int'(str_done), 1);
        check("len0 busy", int'(str_busy), 0);
        step();
        check("len0 done cleared", int'(str_done), 0);
        step(5);
        check("len0 no access", q_en.size() - m_en, 0);
        check("len0 done count", q_dn.size() - m_dn, 1);

        // A start while busy is ignored.
        mark();
        start_stream('h100, 3);
        step();
        check("ignore busy", int'(str_busy), 1);
        start_stream('h200, 5);
        str_base = '0;
        str_len  = '0;
        wait_done("ignore", 200, 60);
        step(2);
        check_stream("ignore", 'h100, 3, 1'b1);

        // Host request held high through a stream: grants alternate.
        mark();
        host_req  = 1'b1;
        host_rw   = 1'b0;
        host_addr = AW'(HOST_TAG);
        start_stream('h20, 4);
        wait_done("alt", 200, 100);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (host_ack) begin
                ok = 1'b1;
                break;
            end
        end
        host_req = 1'b0;
        if (!ok) timeout_fail("alt final ack");
        step(2);
        check("alt grant count", int'(q_en.size() - m_en >= 8), 1);
        for (int i = 0; i < 8; i++)
            if (m_en + i < q_en.size())
                check($sformatf("alt grant%0d", i), int'(q_en[m_en + i]),
                      (i % 2 == 0) ? HOST_TAG : ('h20 + i / 2));
        check("alt no regrant on ack", n_regrant - m_rg, 0);
        check("alt host rdata", int'(host_rdata), exp_byte(HOST_TAG));
        check_stream("alt", 'h20, 4, 1'b0);

        // Reset during the ACC cycle of a stream fetch.
        mark();
        start_stream('h300, 4);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (ram_en) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) timeout_fail("rstmid reach ACC");
        rst = 1'b1;
        step();
        check_zero("rstmid");
        rst = 1'b0;
        step(6);
        check("rstmid no done", q_dn.size() - m_dn, 0);
        check("rstmid busy", int'(str_busy), 0);
        check("rstmid accesses", q_en.size() - m_en, 1);

        // After reset the host wins the first tie.
        mark();
        c0 = cyc;
        start_stream('h400, 2);
        host_req  = 1'b1;
        host_rw   = 1'b0;
        host_addr = AW'('h50010);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (host_ack) begin
                ok = 1'b1;
                break;
            end
        end
        host_req = 1'b0;
        if (!ok) timeout_fail("tie ack");
        check("tie ack cycle", cyc, c0 + 4);
        check("tie host rdata", int'(host_rdata), exp_byte('h50010));
        if (q_en.size() > m_en) check("tie first grant", int'(q_en[m_en]), 'h50010);
        wait_done("tie", 100, 100);
        step(2);
        if (q_en.size() > m_en + 1) check("tie second grant", int'(q_en[m_en + 1]), 'h400);
        check_stream("tie", 'h400, 2, 1'b0);

        // Randomised traffic against the reference model.
        for (int it = 0; it < 15; it++) begin
            int base;
            int len;
            int pct;
            base = $urandom_range(0, 'h3FFFF);
            len  = $urandom_range(1, 12);
            pct  = $urandom_range(30, 100);
            mark();
            fork
                begin
                    start_stream(base, len);
                    wait_done($sformatf("rand%0d", it), 600, pct);
                end
                begin
                    host_rand($urandom_range(1, 4));
                end
            join
            step(2);
            check_stream($sformatf("rand%0d", it), base, len, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/ram_access_ctrl.md
# ram_access_ctrl

Sequencer and arbiter for the single-port 8-bit byte RAM (19-bit address, `rw` select, `en` access strobe). It shares the RAM between two requesters:
- a host port, which does single-byte reads and writes with a req/ack handshake;
- a stream engine, which reads a contiguous block starting at a programmed base and delivers it byte by byte over a valid/ready interface.

It sits between the RAM and the rest of the design and is the only driver of the RAM's address, control and write-data lines.

## Interface
- `AW`, default 19: RAM address width.
- `DW`, default 8: RAM data width.

- `clk` in 1: single system clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `host_req` in 1: host access request; held high until `host_ack`.
- `host_rw` in 1: 0 = read, 1 = write.
- `host_addr` in AW: host byte address.
- `host_wdata` in DW: host write data.
- `host_ack` out 1: one-cycle completion pulse.
- `host_rdata` out DW: read result; valid with `host_ack`, held until the next host read completes.
- `str_start` in 1: start pulse; accepted only when `str_busy`=0.
- `str_base` in AW: first address of the block; sampled on an accepted start.
- `str_len` in AW: byte count; sampled on an accepted start.
- `str_busy` out 1: a stream transfer is in progress.
- `str_data` out DW: stream byte.
- `str_valid` out 1: `str_data` holds an unconsumed byte.
- `str_ready` in 1: the consumer accepts `str_data` this cycle.
- `str_done` out 1: one-cycle pulse at the end of a transfer.
- `ram_en` out 1: RAM access strobe.
- `ram_rw` out 1: RAM direction, 0 = read, 1 = write.
- `ram_addr` out AW: RAM address.
- `ram_wdata` out DW: RAM write data.
- `ram_rdata` in DW: RAM read data; valid in the cycle after the `ram_en` cycle.

## Operation
- FSM states: IDLE, ACC, WAIT.
  - IDLE → ACC on a grant.
  - ACC → WAIT unconditionally.
  - WAIT → IDLE unconditionally.
- Host eligibility: the host is eligible in IDLE when `host_req`=1 and `host_ack`=0. This stops a request from being re-granted while the host is still dropping `host_req` after its ack.
- Stream eligibility: the stream is eligible when `str_busy`=1, the fetch count remaining is >0, and the output buffer is empty (`str_valid`=0).
- Arbitration is round-robin using a `last_grant` flag.
  - If both requesters are eligible, the one not granted last wins.
  - If only one is eligible, it wins.
  - `last_grant` resets to "stream", so the host wins the first tie.
- On a grant, `ram_addr`, `ram_rw` and `ram_wdata` are registered from the winner. They hold stable through ACC and WAIT.
  - The stream always drives `ram_rw`=0.
  - `ram_wdata` is only meaningful for host writes.
- `ram_en`=1 only in ACC.
- In WAIT, `ram_rdata` is captured:
  - host read: into `host_rdata`;
  - stream: into `str_data`.
- Host completion: `host_ack` and, for a read, the updated `host_rdata` appear in the cycle after WAIT. Writes also complete through WAIT, so ack timing is the same for reads and writes.
- Stream completion: `str_valid` rises in the cycle after WAIT. It stays high until `str_valid`&`str_ready`.
- Stream start:
  - An accepted `str_start` latches the base into the address counter and `str_len` into the fetch and consume counters, and sets `str_busy`.
  - With `str_len`=0, `str_done` pulses in the next cycle, `str_busy` is never set, and no RAM access occurs.
- Stream address counter increments by 1 per stream fetch and wraps from 2^AW−1 to 0, modulo 2^AW.
- Completion: the last handshake (`str_valid`&`str_ready` with consume count = 1) clears `str_busy` and pulses `str_done` in the next cycle.
- `str_start` while `str_busy`=1 is ignored.
- Host signals change only while `host_req`=0 or on the `host_ack` cycle. Otherwise behaviour is undefined.

## Timing
- Reset: state IDLE. All outputs are 0: `host_ack`, `host_rdata`, `str_busy`, `str_data`, `str_valid`, `str_done`, `ram_en`, `ram_rw`, `ram_addr`, `ram_wdata`. `last_grant` is set to stream.
- Reset mid-operation: the access is abandoned, `ram_en` drops in the next cycle, the stream is aborted, and there is no `str_done` or `host_ack` pulse.
- Host latency: `host_req` rise in IDLE (cycle 0) → `ram_en` in cycle 1 → capture in cycle 2 → `host_ack` in cycle 3.
- Stream throughput: at most 1 byte per 4 cycles (3 states plus the consume cycle), because a fetch is issued only when the buffer is empty.
- A consume (`str_ready`) and a grant decision in the same cycle: the buffer counts as empty only from the next cycle.

## Test plan
- Host write 0xA5 to 0x00010, then read 0x00010 → `ram_en` pulse in cycle 1 of each access, `host_ack` in cycle 3, `host_rdata`=0xA5.
- Stream with base 0x00000, len 4, RAM preloaded 11, 22, 33, 44, `str_ready`=1 → `str_data` sequence 11, 22, 33, 44; `str_done` pulses once, one cycle after the fourth handshake; `str_busy` then 0.
- Stream with base 0x7FFFE, len 3 → `ram_addr` sequence 0x7FFFE, 0x7FFFF, 0x00000.
- Host request held continuously during a 4-byte stream with `str_ready`=1 → grants alternate host/stream; the host is never re-granted on its ack cycle; all 4 stream bytes arrive in order.
- `str_len`=0 → `str_done` pulse in the next cycle, no `ram_en`; a `str_start` during a busy stream is ignored (base and length unchanged).
- `rst` asserted in ACC of a stream fetch → next cycle all outputs 0, `str_busy`=0, no `str_done`; a host read after reset completes normally.
